// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile_if
//  Description : Bus bundle between the MEM/WB pipeline register, the decode
//                read ports, execute HI/LO consumers and the write-back
//                register file.
//                master : pipeline side (drives write-back bundle and read
//                         requests, receives read data / HI / LO / debug)
//                slave  : register file side
//  Ports       : wb_pc_i, wb_wreg_i, wb_rw_i, wb_wdata_i   GPR write bundle
//                wb_whilo_i, wb_hi_i, wb_lo_i              HI/LO write bundle
//                re1_i/raddr1_i/rdata1_o, re2_i/raddr2_i/rdata2_o  read ports
//                hi_o, lo_o, retire_cnt_o, last_pc_o       status outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] wb_pc_i;
    logic              wb_wreg_i;
    logic [ADDR_W-1:0] wb_rw_i;
    logic [DATA_W-1:0] wb_wdata_i;
    logic              wb_whilo_i;
    logic [DATA_W-1:0] wb_hi_i;
    logic [DATA_W-1:0] wb_lo_i;
    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic [DATA_W-1:0] retire_cnt_o;
    logic [DATA_W-1:0] last_pc_o;

    modport master (
        output wb_pc_i, wb_wreg_i, wb_rw_i, wb_wdata_i,
        output wb_whilo_i, wb_hi_i, wb_lo_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  rdata1_o, rdata2_o, hi_o, lo_o, retire_cnt_o, last_pc_o
    );

    modport slave (
        input  wb_pc_i, wb_wreg_i, wb_rw_i, wb_wdata_i,
        input  wb_whilo_i, wb_hi_i, wb_lo_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output rdata1_o, rdata2_o, hi_o, lo_o, retire_cnt_o, last_pc_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Write-back end of the MEM/WB stage. Commits the registered
//                write-back bundle into a 32-entry GPR file (r0 hard-wired to
//                zero) and the HI/LO pair, serves two combinational read
//                ports, and tracks a retire counter plus last-retired PC.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous reset, active-high
//                bus  - wb_regfile_if.slave (write-back bundle, read ports,
//                       HI/LO, retire counter, last PC)
//  Options     : WB_BYPASS_EN - when defined, same-cycle write-through
//                forwarding of GPR and HI/LO write data to the outputs.
//                When undefined, outputs show stored state only.
//  Parameters  : NUM_REGS must equal 2**ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_regfile_if.slave      bus
);

    localparam logic [DATA_W-1:0] c_one  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_zero = '0;

    logic [DATA_W-1:0] r_gpr [NUM_REGS];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_retire_cnt;
    logic [DATA_W-1:0] r_last_pc;

    logic              w_gpr_we;
    logic              w_hilo_we;
    logic              w_retire;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;

    // A write aimed at r0 is dropped entirely and does not count as retiring.
    assign w_gpr_we  = bus.wb_wreg_i && (bus.wb_rw_i != c_zero);
    assign w_hilo_we = bus.wb_whilo_i;
    assign w_retire  = w_gpr_we || w_hilo_we;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_gpr[i] <= '0;
            end
            r_hi         <= '0;
            r_lo         <= '0;
            r_retire_cnt <= '0;
            r_last_pc    <= '0;
        end else begin
            if (w_gpr_we) begin
                r_gpr[bus.wb_rw_i] <= bus.wb_wdata_i;
            end
            if (w_hilo_we) begin
                r_hi <= bus.wb_hi_i;
                r_lo <= bus.wb_lo_i;
            end
            // One increment per retiring cycle, even if GPR and HI/LO both
            // commit; the counter wraps silently.
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + c_one;
                r_last_pc    <= bus.wb_pc_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port 1
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata1 = '0;
        if (!rst && bus.re1_i && (bus.raddr1_i != c_zero)) begin
`ifdef WB_BYPASS_EN
            if (w_gpr_we && (bus.raddr1_i == bus.wb_rw_i)) begin
                w_rdata1 = bus.wb_wdata_i;
            end else begin
                w_rdata1 = r_gpr[bus.raddr1_i];
            end
`else
            w_rdata1 = r_gpr[bus.raddr1_i];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read port 2
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata2 = '0;
        if (!rst && bus.re2_i && (bus.raddr2_i != c_zero)) begin
`ifdef WB_BYPASS_EN
            if (w_gpr_we && (bus.raddr2_i == bus.wb_rw_i)) begin
                w_rdata2 = bus.wb_wdata_i;
            end else begin
                w_rdata2 = r_gpr[bus.raddr2_i];
            end
`else
            w_rdata2 = r_gpr[bus.raddr2_i];
`endif
        end
    end

    // ------------------------------------------------------------------
    // HI/LO outputs. Gated by rst so a forwarded value never leaks while
    // the block is held in reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        if (!rst) begin
`ifdef WB_BYPASS_EN
            if (w_hilo_we) begin
                w_hi = bus.wb_hi_i;
                w_lo = bus.wb_lo_i;
            end else begin
                w_hi = r_hi;
                w_lo = r_lo;
            end
`else
            w_hi = r_hi;
            w_lo = r_lo;
`endif
        end
    end

    assign bus.rdata1_o     = w_rdata1;
    assign bus.rdata2_o     = w_rdata2;
    assign bus.hi_o         = w_hi;
    assign bus.lo_o         = w_lo;
    assign bus.retire_cnt_o = r_retire_cnt;
    assign bus.last_pc_o    = r_last_pc;

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB stage.
- Consumes the registered write-back bundle (GPR write plus HI/LO write) and commits it into a 32-entry general-purpose register file and the HI/LO register pair.
- Serves the decode stage through two combinational read ports and exposes current HI/LO to execute.
- Keeps a retire counter and last-retired PC for debug and performance visibility.

Parameters:
- DATA_W, 32, width of GPRs, HI, LO, PC and the counter.
- ADDR_W, 5, GPR address width.
- NUM_REGS, 32, number of GPR entries. Must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- wb_pc_i  in  DATA_W  PC of the instruction in write-back.
- wb_wreg_i  in  1  GPR write enable.
- wb_rw_i  in  ADDR_W  GPR destination address.
- wb_wdata_i  in  DATA_W  GPR write data.
- wb_whilo_i  in  1  HI/LO write enable.
- wb_hi_i  in  DATA_W  HI write data.
- wb_lo_i  in  DATA_W  LO write data.
- re1_i  in  1  read port 1 enable.
- raddr1_i  in  ADDR_W  read port 1 address.
- rdata1_o  out  DATA_W  read port 1 data (combinational).
- re2_i  in  1  read port 2 enable.
- raddr2_i  in  ADDR_W  read port 2 address.
- rdata2_o  out  DATA_W  read port 2 data (combinational).
- hi_o  out  DATA_W  current HI value.
- lo_o  out  DATA_W  current LO value.
- retire_cnt_o  out  DATA_W  count of retiring write-back cycles.
- last_pc_o  out  DATA_W  PC of the most recently retired instruction.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: while rst=1, immediately and independent of clk:
  - all GPR entries = 0, HI = 0, LO = 0;
  - retire_cnt_o = 0, last_pc_o = 0;
  - rdata1_o/rdata2_o = 0, hi_o = lo_o = 0.
- Reset mid-operation: a write presented in the same cycle rst asserts is discarded.
- Reset release: first commit occurs at the first rising edge with rst=0.
- GPR write: at posedge, if wb_wreg_i=1 and wb_rw_i!=0, then GPR[wb_rw_i] <= wb_wdata_i. Writes to r0 are dropped; r0 always reads 0.
- HI/LO write: at posedge, if wb_whilo_i=1, then HI <= wb_hi_i and LO <= wb_lo_i, both updated together. There is no partial update.
- Read ports, combinational, zero added latency, evaluated independently. Priority per port:
  1. rst=1 -> 0.
  2. re=0 -> 0.
  3. raddr=0 -> 0.
  4. Bypass match (see Optional Feature).
  5. Otherwise GPR[raddr].
- Both read ports may address the same register; each returns the identical value.
- Retire event = (wb_wreg_i=1 and wb_rw_i!=0) or wb_whilo_i=1.
  - On a retire event at posedge: retire_cnt_o <= retire_cnt_o+1 and last_pc_o <= wb_pc_i.
  - Counter wraps from 2**DATA_W-1 to 0 with no flag.
  - A write to r0 without wb_whilo_i is not a retire event.
- Simultaneous GPR and HI/LO write in one cycle: both commit; counter increments by exactly 1.
- Back-to-back writes to the same address: the last write wins. Each write is visible per the bypass rules.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-through forwarding.
  - If wb_wreg_i=1, wb_rw_i!=0, re=1 and raddr==wb_rw_i, the read port returns wb_wdata_i in the same cycle.
  - If wb_whilo_i=1, hi_o/lo_o return wb_hi_i/wb_lo_i in the same cycle.
  - Forwarding resolves the WB-to-ID hazard.
- Undefined: read ports and hi_o/lo_o return stored state only. A write becomes visible the cycle after its commit edge, and the pipeline must stall or forward externally.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after loading r5=0x12345678 -> rdata1_o (raddr1=5, re1=1), hi_o, lo_o, retire_cnt_o and last_pc_o all read 0 immediately, before the next clk edge.
- Write/read: write r3=0xDEADBEEF with wb_pc_i=0x00000010 -> next cycle rdata1_o=rdata2_o=0xDEADBEEF (both ports addressing 3), retire_cnt_o=1, last_pc_o=0x10. With re2=0, rdata2_o=0.
- r0 protection: wb_wreg_i=1, wb_rw_i=0, wb_wdata_i=0xFFFFFFFF -> reading r0 returns 0; retire_cnt_o and last_pc_o unchanged.
- HI/LO plus simultaneous GPR: wb_whilo_i=1 with hi=0x1, lo=0x2, and in the same cycle a write of r7=0x77 -> next cycle hi_o=0x1, lo_o=0x2, r7=0x77, retire_cnt_o incremented by 1.
- Bypass: write r9=0xA5A5A5A5 while raddr1_i=9 in the same cycle:
  - WB_BYPASS_EN defined -> rdata1_o=0xA5A5A5A5 that cycle.
  - Undefined -> old r9 value that cycle, 0xA5A5A5A5 the next cycle.
- Wrap: force retire_cnt to 0xFFFFFFFF, then one retire event -> retire_cnt_o=0x00000000.
